// File: rtl/frame_event_scheduler_pkg.sv
// Shared types and helpers for the frame event scheduler.
package frame_event_scheduler_pkg;

    localparam int unsigned DefNch  = 4;
    localparam int unsigned DefCntw = 6;

    // Per-channel state.
    typedef enum logic {
        ChIdle  = 1'b0,
        ChArmed = 1'b1
    } ch_state_e;

    // Mode encodings for cfg_periodic.
    typedef enum logic {
        ModeOneShot  = 1'b0,
        ModePeriodic = 1'b1
    } ch_mode_e;

    // Increment with wrap at n (n need not be a power of two).
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/frame_event_scheduler_if.sv
// Config, event handshake and status bundle of the frame event scheduler.
interface frame_event_scheduler_if #(
    parameter int unsigned NCH  = 4,
    parameter int unsigned CNTW = 6,
    parameter int unsigned CHW  = $clog2(NCH)
);
    logic            vsync;
    logic            cfg_we;
    logic [CHW-1:0]  cfg_ch;
    logic            cfg_en;
    logic            cfg_periodic;
    logic [CNTW-1:0] cfg_period;
    logic            evt_ready;
    logic            evt_valid;
    logic [CHW-1:0]  evt_ch;
    logic            frame_tick;
    logic [NCH-1:0]  armed;
    logic [NCH-1:0]  pending;
    logic [NCH-1:0]  overrun;

    modport master (
        output vsync, cfg_we, cfg_ch, cfg_en, cfg_periodic, cfg_period, evt_ready,
        input  evt_valid, evt_ch, frame_tick, armed, pending, overrun
    );

    modport slave (
        input  vsync, cfg_we, cfg_ch, cfg_en, cfg_periodic, cfg_period, evt_ready,
        output evt_valid, evt_ch, frame_tick, armed, pending, overrun
    );
endinterface

// File: rtl/frame_event_channel.sv
// One frame-period timer: counts frame ticks down and strobes on expiry.
module frame_event_channel
    import frame_event_scheduler_pkg::*;
#(
    parameter int unsigned CNTW = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tick,
    input  logic            cfg_we,
    input  logic            cfg_en,
    input  logic            cfg_periodic,
    input  logic [CNTW-1:0] cfg_period,
    output logic            armed,
    output logic            expire
);
    ch_state_e       state_q;
    ch_mode_e        mode_q;
    logic [CNTW-1:0] cnt_q;
    logic [CNTW-1:0] period_q;
    logic [CNTW-1:0] load_val;

    // A programmed period of 0 behaves as 1.
    assign load_val = (cfg_period == '0) ? CNTW'(1) : cfg_period;

    // A config write in the same cycle wins over the expiry.
    assign expire = (state_q == ChArmed) && tick && (cnt_q == CNTW'(1)) && !cfg_we;
    assign armed  = (state_q == ChArmed);

    // Channel FSM: config, countdown, reload or stop on expiry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ChIdle;
            mode_q   <= ModeOneShot;
            cnt_q    <= '0;
            period_q <= '0;
        end else if (cfg_we) begin
            if (cfg_en) begin
                state_q  <= ChArmed;
                mode_q   <= ch_mode_e'(cfg_periodic);
                cnt_q    <= load_val;
                period_q <= load_val;
            end else begin
                state_q <= ChIdle;
                cnt_q   <= '0;
            end
        end else if (state_q == ChArmed && tick) begin
            if (cnt_q > CNTW'(1)) begin
                cnt_q <= cnt_q - CNTW'(1);
            end else if (mode_q == ModePeriodic) begin
                cnt_q <= period_q;
            end else begin
                state_q <= ChIdle;
                cnt_q   <= '0;
            end
        end
    end
endmodule

// File: rtl/frame_event_scheduler.sv
// Shares the vsync frame tick between NCH timers and presents their expiries
// one at a time on a valid/ready port with round-robin arbitration.
module frame_event_scheduler
    import frame_event_scheduler_pkg::*;
#(
    parameter int unsigned NCH  = DefNch,
    parameter int unsigned CNTW = DefCntw,
    parameter int unsigned CHW  = $clog2(NCH)
) (
    input logic clk,
    input logic reset,
    frame_event_scheduler_if.slave bus
);
    logic           vsync_q;
    logic           frame_tick_q;
    logic [NCH-1:0] pending_q, pending_d;
    logic [NCH-1:0] overrun_q, overrun_d;
    logic [NCH-1:0] expire;
    logic [NCH-1:0] armed_w;
    logic [NCH-1:0] cfg_sel;
    logic [CHW-1:0] rr_ptr_q, rr_ptr_d;
    logic           evt_valid_q, evt_valid_d;
    logic [CHW-1:0] evt_ch_q, evt_ch_d;
    logic [CHW-1:0] winner;
    logic           found;
    logic           load;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign cfg_sel[i] = bus.cfg_we && (bus.cfg_ch == CHW'(i));

        frame_event_channel #(.CNTW(CNTW)) u_ch (
            .clk          (clk),
            .reset        (reset),
            .tick         (frame_tick_q),
            .cfg_we       (cfg_sel[i]),
            .cfg_en       (bus.cfg_en),
            .cfg_periodic (bus.cfg_periodic),
            .cfg_period   (bus.cfg_period),
            .armed        (armed_w[i]),
            .expire       (expire[i])
        );
    end

    // Round-robin pick: first pending channel at or above rr_ptr, wrapping.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            logic [CHW-1:0] idx;
            idx = CHW'((32'(rr_ptr_q) + k) % NCH);
            if (!found && pending_q[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
        load = (!evt_valid_q || bus.evt_ready) && found;
    end

    // Pending/overrun bookkeeping and output register next state.
    always_comb begin
        pending_d   = pending_q;
        overrun_d   = overrun_q;
        rr_ptr_d    = rr_ptr_q;
        evt_valid_d = evt_valid_q;
        evt_ch_d    = evt_ch_q;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (load && winner == CHW'(i)) begin
                pending_d[i] = 1'b0;
            end
            if (expire[i]) begin
                // Being drained this cycle frees the slot, so no overrun.
                if (pending_q[i] && !(load && winner == CHW'(i))) begin
                    overrun_d[i] = 1'b1;
                end
                pending_d[i] = 1'b1;
            end
            if (cfg_sel[i]) begin
                overrun_d[i] = 1'b0;
                if (!bus.cfg_en) begin
                    pending_d[i] = 1'b0;
                end
            end
        end
        if (load) begin
            evt_valid_d = 1'b1;
            evt_ch_d    = winner;
            rr_ptr_d    = CHW'(wrap_inc(32'(winner), NCH));
        end else if (bus.evt_ready) begin
            evt_valid_d = 1'b0;
        end
    end

    // All scheduler state, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsync_q      <= 1'b0;
            frame_tick_q <= 1'b0;
            pending_q    <= '0;
            overrun_q    <= '0;
            rr_ptr_q     <= '0;
            evt_valid_q  <= 1'b0;
            evt_ch_q     <= '0;
        end else begin
            vsync_q      <= bus.vsync;
            frame_tick_q <= vsync_q & ~bus.vsync;
            pending_q    <= pending_d;
            overrun_q    <= overrun_d;
            rr_ptr_q     <= rr_ptr_d;
            evt_valid_q  <= evt_valid_d;
            evt_ch_q     <= evt_ch_d;
        end
    end

    assign bus.frame_tick = frame_tick_q;
    assign bus.armed      = armed_w;
    assign bus.pending    = pending_q;
    assign bus.overrun    = overrun_q;
    assign bus.evt_valid  = evt_valid_q;
    assign bus.evt_ch     = evt_ch_q;
endmodule

// File: tb/tb_frame_event_scheduler.sv
// Directed bench for frame_event_scheduler with hand-computed expectations.
module tb_frame_event_scheduler;
    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;

    frame_event_scheduler_if #(.NCH(4), .CNTW(6), .CHW(2)) fe_if ();

    frame_event_scheduler #(.NCH(4), .CNTW(6), .CHW(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (fe_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One vsync high/low; returns in the cycle where frame_tick is high.
    task automatic pulse_vsync();
        fe_if.vsync = 1'b1;
        step();
        fe_if.vsync = 1'b0;
        step();
    endtask

    task automatic cfg(input int ch, input bit en, input bit per, input int period);
        fe_if.cfg_ch       = 2'(ch);
        fe_if.cfg_en       = en;
        fe_if.cfg_periodic = per;
        fe_if.cfg_period   = 6'(period);
        fe_if.cfg_we       = 1'b1;
        step();
        fe_if.cfg_we       = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        step();
    endtask

    initial begin
        n_pass             = 0;
        n_total            = 0;
        reset              = 1'b1;
        fe_if.vsync        = 1'b0;
        fe_if.cfg_we       = 1'b0;
        fe_if.cfg_ch       = '0;
        fe_if.cfg_en       = 1'b0;
        fe_if.cfg_periodic = 1'b0;
        fe_if.cfg_period   = '0;
        fe_if.evt_ready    = 1'b0;
        step();
        step();
        check("rst_valid", 32'(fe_if.evt_valid), 0);
        check("rst_tick", 32'(fe_if.frame_tick), 0);
        check("rst_pend", 32'(fe_if.pending), 0);
        check("rst_armed", 32'(fe_if.armed), 0);
        check("rst_ovr", 32'(fe_if.overrun), 0);
        reset = 1'b0;
        step();

        // 1: three vsync falls, three single-cycle ticks, no events
        for (int t = 0; t < 3; t++) begin
            pulse_vsync();
            check("t1_tick_hi", 32'(fe_if.frame_tick), 1);
            step();
            check("t1_tick_lo", 32'(fe_if.frame_tick), 0);
            check("t1_novalid", 32'(fe_if.evt_valid), 0);
        end

        // 2: ch1 periodic period 3, events on ticks 3, 6, 9
        fe_if.evt_ready = 1'b1;
        cfg(1, 1'b1, 1'b1, 3);
        check("t2_armed", 32'(fe_if.armed), 32'h2);
        for (int k = 1; k <= 9; k++) begin
            pulse_vsync();
            step();
            step();
            check($sformatf("t2_valid_k%0d", k), 32'(fe_if.evt_valid), (k % 3 == 0) ? 1 : 0);
            if (k % 3 == 0) begin
                check($sformatf("t2_ch_k%0d", k), 32'(fe_if.evt_ch), 1);
            end
        end
        cfg(1, 1'b0, 1'b0, 0);
        check("t2_disarm", 32'(fe_if.armed), 0);

        // 3: ch0 one-shot period 0 behaves as 1
        cfg(0, 1'b1, 1'b0, 0);
        check("t3_armed", 32'(fe_if.armed), 32'h1);
        pulse_vsync();
        step();
        check("t3_idle", 32'(fe_if.armed), 0);
        check("t3_pend", 32'(fe_if.pending), 32'h1);
        step();
        check("t3_valid", 32'(fe_if.evt_valid), 1);
        check("t3_ch", 32'(fe_if.evt_ch), 0);
        pulse_vsync();
        step();
        step();
        check("t3_once", 32'(fe_if.evt_valid), 0);

        // 4: all four periodic period 2, back-to-back 0,1,2,3 from rr_ptr 0
        pulse_reset();
        fe_if.evt_ready = 1'b1;
        for (int c = 0; c < 4; c++) cfg(c, 1'b1, 1'b1, 2);
        check("t4_armed", 32'(fe_if.armed), 32'hF);
        for (int r = 0; r < 2; r++) begin
            pulse_vsync();
            step();
            pulse_vsync();
            step();
            check($sformatf("t4_pend_r%0d", r), 32'(fe_if.pending), 32'hF);
            for (int c = 0; c < 4; c++) begin
                step();
                check($sformatf("t4_valid_r%0d_%0d", r, c), 32'(fe_if.evt_valid), 1);
                check($sformatf("t4_ch_r%0d_%0d", r, c), 32'(fe_if.evt_ch), 32'(c));
            end
            step();
            check($sformatf("t4_drained_r%0d", r), 32'(fe_if.evt_valid), 0);
        end
        for (int c = 0; c < 4; c++) cfg(c, 1'b0, 1'b0, 0);

        // 5: ch2 period 1 with consumer stalled: held event, overrun
        fe_if.evt_ready = 1'b0;
        cfg(2, 1'b1, 1'b1, 1);
        pulse_vsync();
        step();
        step();
        check("t5_valid", 32'(fe_if.evt_valid), 1);
        check("t5_ch", 32'(fe_if.evt_ch), 2);
        check("t5_pend0", 32'(fe_if.pending), 0);
        pulse_vsync();
        step();
        check("t5_pend1", 32'(fe_if.pending), 32'h4);
        check("t5_noovr", 32'(fe_if.overrun), 0);
        check("t5_hold_ch", 32'(fe_if.evt_ch), 2);
        pulse_vsync();
        step();
        check("t5_ovr", 32'(fe_if.overrun), 32'h4);
        check("t5_pend2", 32'(fe_if.pending), 32'h4);
        check("t5_hold_v", 32'(fe_if.evt_valid), 1);
        cfg(2, 1'b1, 1'b1, 5);
        check("t5_ovr_clr", 32'(fe_if.overrun), 0);
        check("t5_pend_kept", 32'(fe_if.pending), 32'h4);

        // 6: reset while an event is presented and ch2 is mid-count
        pulse_vsync();
        step();
        check("t6_pre_valid", 32'(fe_if.evt_valid), 1);
        #2;
        reset = 1'b1;
        #1;
        check("t6_valid", 32'(fe_if.evt_valid), 0);
        check("t6_pend", 32'(fe_if.pending), 0);
        check("t6_armed", 32'(fe_if.armed), 0);
        check("t6_ch", 32'(fe_if.evt_ch), 0);
        step();
        reset = 1'b0;
        fe_if.evt_ready = 1'b1;
        for (int t = 0; t < 6; t++) begin
            pulse_vsync();
            step();
            step();
            check($sformatf("t6_quiet_%0d", t), 32'({fe_if.evt_valid, fe_if.pending}), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
